// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_BE_W  = 4;
  localparam int DMEM_LAT_W = 4;

  // Request fields still needed after the accept edge; store data was already
  // committed to the array on that edge.
  typedef struct packed {
    logic        write;
    logic        err;
    logic [31:0] addr;
  } dmem_req_t;

  function automatic logic [31:0] dmem_merge(input logic [31:0]          old_word,
                                             input logic [31:0]          new_word,
                                             input logic [DMEM_BE_W-1:0] byte_en);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < DMEM_BE_W; b++) begin
      if (byte_en[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: byte-enabled synchronous write, combinational read,
// every word cleared while reset is held.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [31:0]          wdata,
  input  logic [DMEM_BE_W-1:0] byte_en,
  input  logic [IDX_W-1:0]     raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: clearing a memory in reset forces it into flops rather than RAM
  // macros; it is deliberate here because loads after reset must return 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DMEM_BE_W; b++) begin
        if (byte_en[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the load/store interface: one request at a time, LATENCY wait
// states, held response. Define DMEM_TRACE_EN to print a line per store accept.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [DMEM_BE_W-1:0] req_byte_en,
  input  logic [31:0]          req_pc,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [DMEM_LAT_W-1:0] LAT_INIT =
    (LATENCY > 0) ? DMEM_LAT_W'(LATENCY - 1) : '0;

  dmem_state_e           state, state_next;
  logic [DMEM_LAT_W-1:0] wait_cnt, wait_cnt_next;
  dmem_req_t             req_q, cur;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  req_err;
  logic [IDX_W-1:0]      req_idx, rd_idx;
  logic [31:0]           arr_rdata;

  assign accept = req_valid && req_ready;

  // Unsigned compare carried in 33 bits so the upper bound cannot wrap.
  assign req_err = (req_addr < ADDR_BASE) ||
                   ({1'b0, req_addr} >= ADDR_LIMIT) ||
                   (req_addr[1:0] != 2'b00);
  assign req_idx = IDX_W'((req_addr - ADDR_BASE) >> 2);

  // In IDLE the live request is the one in flight (LATENCY=0 responds on the
  // accept edge); afterwards the latched copy is.
  assign cur    = (state == DMEM_IDLE) ? '{write: req_write, err: req_err, addr: req_addr}
                                       : req_q;
  assign rd_idx = IDX_W'((cur.addr - ADDR_BASE) >> 2);

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (accept && req_write && !req_err),
    .waddr   (req_idx),
    .wdata   (req_wdata),
    .byte_en (req_byte_en),
    .raddr   (rd_idx),
    .rdata   (arr_rdata)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DMEM_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned
  // (which would infer a latch).
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      DMEM_IDLE: begin
        if (accept) begin
          if (LATENCY > 0) begin
            state_next    = DMEM_WAIT;
            wait_cnt_next = LAT_INIT;
          end else begin
            state_next = DMEM_RESP;
          end
        end
      end
      DMEM_WAIT: begin
        if (wait_cnt == '0) state_next = DMEM_RESP;
        else                wait_cnt_next = wait_cnt - 1'b1;
      end
      DMEM_RESP: begin
        if (resp_ready) state_next = DMEM_IDLE;
      end
      default: state_next = DMEM_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = !reset && (state == DMEM_IDLE);
    resp_valid = !reset && (state == DMEM_RESP);
    resp_rdata = reset ? '0 : rdata_q;
    resp_err   = !reset && err_q;
  end

  // Response data is captured once on entry to RESP and held until handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) req_q <= cur;
      if ((state_next == DMEM_RESP) && (state != DMEM_RESP)) begin
        rdata_q <= (cur.write || cur.err) ? '0 : arr_rdata;
        err_q   <= cur.err;
      end
    end
  end

`ifdef DMEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && accept && req_write) begin
      if (req_err)
        $display("ERR %d@%h: *%h <= %h", $time, req_pc, req_addr,
                 dmem_merge(32'h0, req_wdata, req_byte_en));
      else
        $display("%d@%h: *%h <= %h", $time, req_pc, req_addr,
                 dmem_merge(arr_rdata, req_wdata, req_byte_en));
    end
  end
`else
  logic unused_trace_pc;
  assign unused_trace_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: LATENCY=2 responder for the main sequence plus
// a LATENCY=0 instance for single-cycle response and throughput.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [3:0]  req_byte_en;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid_l0, req_ready_l0, req_write_l0;
  logic [31:0] req_addr_l0, req_wdata_l0, req_pc_l0;
  logic [3:0]  req_byte_en_l0;
  logic        resp_valid_l0, resp_ready_l0, resp_err_l0;
  logic [31:0] resp_rdata_l0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_l0), .req_ready(req_ready_l0), .req_write(req_write_l0),
    .req_addr(req_addr_l0), .req_wdata(req_wdata_l0), .req_byte_en(req_byte_en_l0),
    .req_pc(req_pc_l0),
    .resp_valid(resp_valid_l0), .resp_ready(resp_ready_l0),
    .resp_rdata(resp_rdata_l0), .resp_err(resp_err_l0)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full transaction on the LATENCY=2 instance; lat counts negedges from
  // the accept edge up to the first one showing resp_valid.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_byte_en = be; req_pc = 32'h0000_4000 + addr;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 50);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    do_req(wr, addr, wdata, be, rdata, err, lat);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "_lat"}, 32'(lat), 32'd3);
  endtask

  initial begin
    logic [31:0] held_rdata;
    int          guard;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_byte_en = '0; req_pc = '0; resp_ready = 1'b0;
    req_valid_l0 = 1'b0; req_write_l0 = 1'b0; req_addr_l0 = '0; req_wdata_l0 = '0;
    req_byte_en_l0 = '0; req_pc_l0 = '0; resp_ready_l0 = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    check("idle_resp_valid", {31'b0, resp_valid}, 32'd0);

    run("ld0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);

    run("st10_full", 1'b1, 32'h10, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
    run("ld10_a", 1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    run("st10_part", 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    run("ld10_b", 1'b0, 32'h10, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0);
    run("st10_nobe", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    run("ld10_c", 1'b0, 32'h10, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0);

    // Backpressure: response must hold for five stalled cycles.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_byte_en = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!resp_valid && guard < 50);
    check("bp_first_valid", 32'(guard), 32'd3);
    held_rdata = resp_rdata;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, 32'h12BB_56DD);
      check("bp_err", {31'b0, resp_err}, 32'd0);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    check("bp_stable", resp_rdata, held_rdata);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("bp_done_valid", {31'b0, resp_valid}, 32'd0);
    check("bp_done_ready", {31'b0, req_ready}, 32'd1);

    run("ld_misaligned", 1'b0, 32'h1002, 32'h0, 4'h0, 32'h0, 1'b1);
    run("st_ffc", 1'b1, 32'hFFC, 32'h1122_3344, 4'b1111, 32'h0, 1'b0);
    run("st_oob", 1'b1, 32'h1000, 32'h5566_7788, 4'b1111, 32'h0, 1'b1);
    run("ld_ffc", 1'b0, 32'hFFC, 32'h0, 4'h0, 32'h1122_3344, 1'b0);
    run("ld0_after_oob", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    run("st_misaligned", 1'b1, 32'h11, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    run("ld10_d", 1'b0, 32'h10, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0);

    // Reset while the store to 0x20 is waiting.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hDEAD_BEEF; req_byte_en = 4'b1111;
    @(posedge clk);
    #1 begin
      req_valid = 1'b0;
      reset = 1'b1;
    end
    @(negedge clk);
    check("rstmid_valid", {31'b0, resp_valid}, 32'd0);
    check("rstmid_ready", {31'b0, req_ready}, 32'd0);
    check("rstmid_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstmid_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    check("rstmid_idle", {31'b0, req_ready}, 32'd1);
    run("ld20_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
    run("ld10_after_rst", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

    // LATENCY=0 instance: response in the cycle after accept, one request per 2 cycles.
    @(negedge clk);
    resp_ready_l0 = 1'b1;
    req_valid_l0 = 1'b1; req_write_l0 = 1'b1; req_addr_l0 = 32'h8;
    req_wdata_l0 = 32'hCAFE_F00D; req_byte_en_l0 = 4'b1111;
    check("l0_ready", {31'b0, req_ready_l0}, 32'd1);
    @(posedge clk);
    #1 req_write_l0 = 1'b0;
    @(negedge clk);
    check("l0_st_valid", {31'b0, resp_valid_l0}, 32'd1);
    check("l0_st_err", {31'b0, resp_err_l0}, 32'd0);
    check("l0_st_rdata", resp_rdata_l0, 32'h0);
    check("l0_st_ready", {31'b0, req_ready_l0}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        check("l0_tp_ready_hi", {31'b0, req_ready_l0}, 32'd1);
        check("l0_tp_valid_lo", {31'b0, resp_valid_l0}, 32'd0);
      end else begin
        check("l0_tp_ready_lo", {31'b0, req_ready_l0}, 32'd0);
        check("l0_tp_valid_hi", {31'b0, resp_valid_l0}, 32'd1);
        check("l0_tp_rdata", resp_rdata_l0, 32'hCAFE_F00D);
      end
    end
    req_valid_l0 = 1'b0;
    resp_ready_l0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
